// File: rtl/control_actuadores.sv
// Alarm actuator control: debounces the 2-bit alert code and drives buzzer/fan through a Moore FSM.
// Accepted code reaches estado DEB_CYC+2 edges after it first appears; no backpressure, inputs sampled every cycle.
module control_actuadores #(
   parameter int DEB_CYC   = 4,
   parameter int BLINK_CYC = 8,
   parameter int HOLD_CYC  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] Salida,
   input  logic       ack,
   output logic       buzzer,
   output logic       ventilador,
   output logic [1:0] estado
);

   localparam int DEB_W   = $clog2(DEB_CYC) + 1;
   localparam int BLINK_W = $clog2(BLINK_CYC) + 1;
   localparam int HOLD_W  = $clog2(HOLD_CYC) + 1;

   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYC - 1);
   localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);
   localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
   localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

   typedef enum logic [1:0] {
      REPOSO = 2'b00,
      PRE    = 2'b01,
      ENFRIA = 2'b10,
      ALERTA = 2'b11
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         code_map;
   logic [1:0]         candidate;
   logic [1:0]         validated;
   logic [DEB_W-1:0]   deb_cnt;
   logic [BLINK_W-1:0] blink_cnt;
   logic [HOLD_W-1:0]  hold_cnt;
   logic               silencio;
   logic               blink;
   logic               code_danger;
   logic               code_warn;
   logic               code_clear;

   // The unused 10 code is folded onto the dangerous code so a bad source fails safe.
   assign code_map = (Salida == 2'b10) ? 2'b11 : Salida;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         candidate <= 2'b00;
         validated <= 2'b00;
         deb_cnt   <= '0;
      end else if (code_map != candidate) begin
         candidate <= code_map;
         deb_cnt   <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         validated <= candidate;
      end else begin
         deb_cnt <= deb_cnt + DEB_ONE;
      end
   end

   assign code_danger = validated[1];
   assign code_warn   = (validated == 2'b01);
   assign code_clear  = (validated == 2'b00);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= REPOSO;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         REPOSO: begin
            if (code_danger)    state_nxt = ALERTA;
            else if (code_warn) state_nxt = PRE;
         end
         PRE: begin
            if (code_danger)     state_nxt = ALERTA;
            else if (code_clear) state_nxt = REPOSO;
         end
         ALERTA: begin
            if (code_warn)       state_nxt = PRE;
            else if (code_clear) state_nxt = ENFRIA;
         end
         ENFRIA: begin
            // A returning alert preempts the run-on timeout.
            if (code_danger)                 state_nxt = ALERTA;
            else if (code_warn)              state_nxt = PRE;
            else if (hold_cnt == HOLD_LAST)  state_nxt = REPOSO;
         end
         default: state_nxt = REPOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         silencio  <= 1'b0;
         blink     <= 1'b0;
         blink_cnt <= '0;
         hold_cnt  <= '0;
      end else if (state_nxt != state) begin
         silencio  <= 1'b0;
         blink     <= (state_nxt == PRE);
         blink_cnt <= '0;
         hold_cnt  <= '0;
      end else begin
         if (ack && (state == PRE || state == ALERTA)) begin
            silencio <= 1'b1;
         end
         if (state == PRE) begin
            if (blink_cnt == BLINK_LAST) begin
               blink     <= ~blink;
               blink_cnt <= '0;
            end else begin
               blink_cnt <= blink_cnt + BLINK_ONE;
            end
         end
         if (state == ENFRIA && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
         end
      end
   end

   assign ventilador = (state == ALERTA) || (state == ENFRIA);
   assign buzzer     = !silencio && ((state == ALERTA) || (state == PRE && blink));
   assign estado     = state;

endmodule

// File: tb/tb_control_actuadores.sv
// Bench for control_actuadores: directed scenarios plus randomized traffic against a run-length / time-in-state model.
module tb_control_actuadores;

   localparam int DEB   = 4;
   localparam int BLINK = 8;
   localparam int HOLD  = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] Salida = 2'b00;
   logic       ack = 1'b0;
   logic       buzzer;
   logic       ventilador;
   logic [1:0] estado;

   int n_cmp = 0;
   int n_err = 0;

   control_actuadores #(.DEB_CYC(DEB), .BLINK_CYC(BLINK), .HOLD_CYC(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .Salida(Salida), .ack(ack),
      .buzzer(buzzer), .ventilador(ventilador), .estado(estado)
   );

   always #5 clk = ~clk;

   // Model: a code is accepted once seen on DEB+1 consecutive edges; state timing uses time-in-state m_t.
   logic [1:0] m_state = 2'b00;
   logic [1:0] m_val   = 2'b00;
   logic [1:0] m_last  = 2'b00;
   int         m_run   = 1;
   int         m_t     = 0;
   bit         m_sil   = 1'b0;

   function automatic logic [3:0] exp_out();
      logic fan, buz;
      fan = (m_state == 2'b11) || (m_state == 2'b10);
      buz = !m_sil && ((m_state == 2'b11) || (m_state == 2'b01 && ((m_t / BLINK) % 2 == 0)));
      return {m_state, fan, buz};
   endfunction

   task automatic model_edge(input logic [1:0] s, input logic a, input logic r);
      logic [1:0] mapped, nxt;
      mapped = (s == 2'b10) ? 2'b11 : s;
      if (!r) begin
         m_state = 2'b00; m_val = 2'b00; m_last = 2'b00; m_run = 1; m_t = 0; m_sil = 1'b0;
      end else begin
         nxt = m_state;
         case (m_state)
            2'b00: nxt = m_val;
            2'b01: nxt = m_val;
            2'b11: nxt = (m_val == 2'b00) ? 2'b10 : m_val;
            default: nxt = (m_val != 2'b00) ? m_val : ((m_t == HOLD - 1) ? 2'b00 : 2'b10);
         endcase
         if (nxt != m_state) begin
            m_state = nxt; m_t = 0; m_sil = 1'b0;
         end else begin
            m_t++;
            if (a && (m_state == 2'b01 || m_state == 2'b11)) m_sil = 1'b1;
         end
         if (mapped == m_last) m_run++;
         else begin m_last = mapped; m_run = 1; end
         if (m_run >= DEB + 1) m_val = m_last;
      end
   endtask

   task automatic step(input logic [1:0] s, input logic a, input logic r);
      Salida = s; ack = a; rst_n = r;
      @(posedge clk);
      model_edge(s, a, r);
      @(negedge clk);
   endtask

   task automatic test_reset();
      int first;
      first = -1;
      step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      n_cmp++;
      if ({estado, ventilador, buzzer} !== 4'b0000) begin
         n_err++; $display("FAIL reset_state got %b exp 0000", {estado, ventilador, buzzer});
      end
      for (int e = 1; e <= 10; e++) begin
         step(2'b11, 1'b0, 1'b1);
         n_cmp++;
         if ({estado, ventilador, buzzer} !== exp_out()) begin
            n_err++; $display("FAIL reset_release edge %0d got %b exp %b", e, {estado, ventilador, buzzer}, exp_out());
         end
         if (first < 0 && estado == 2'b11) first = e;
      end
      n_cmp++;
      if (first !== 6) begin
         n_err++; $display("FAIL reset_latency got edge %0d exp 6", first);
      end
      n_cmp++;
      if ({buzzer, ventilador} !== 2'b11) begin
         n_err++; $display("FAIL reset_alerta_out got %b exp 11", {buzzer, ventilador});
      end
   endtask

   task automatic test_glitch();
      step(2'b00, 1'b0, 1'b0);
      step(2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(2'b00, 1'b0, 1'b1);
         n_cmp++;
         if (estado !== 2'b00) begin
            n_err++; $display("FAIL glitch_short cyc %0d got %b exp 00", i, estado);
         end
      end
      for (int i = 0; i < 5; i++) step(2'b01, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b1);
      n_cmp++;
      if (estado !== 2'b01) begin
         n_err++; $display("FAIL glitch_hold5 got %b exp 01", estado);
      end
   endtask

   task automatic test_blink();
      step(2'b00, 1'b0, 1'b0);
      for (int e = 1; e <= 45; e++) begin
         step(2'b01, 1'b0, 1'b1);
         n_cmp++;
         if ({estado, ventilador, buzzer} !== exp_out()) begin
            n_err++; $display("FAIL blink_model edge %0d got %b exp %b", e, {estado, ventilador, buzzer}, exp_out());
         end
         if (e >= 6) begin
            n_cmp++;
            if ({estado, ventilador, buzzer} !== {2'b01, 1'b0, (((e - 6) / 8) % 2 == 0)}) begin
               n_err++; $display("FAIL blink_phase k=%0d got %b exp est=01 fan=0 buz=%0d", e - 6,
                                 {estado, ventilador, buzzer}, (((e - 6) / 8) % 2 == 0));
            end
         end
      end
   endtask

   task automatic test_runon();
      int n, cnt;
      bit saw_reposo;
      step(2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(2'b11, 1'b0, 1'b1);
      n = 0;
      while (estado != 2'b10 && n < 20) begin step(2'b00, 1'b0, 1'b1); n++; end
      n_cmp++;
      if (estado !== 2'b10) begin
         n_err++; $display("FAIL runon_enter got %b exp 10", estado);
      end
      cnt = 0;
      while (estado == 2'b10 && ventilador == 1'b1 && cnt < 40) begin
         cnt++;
         step(2'b00, 1'b0, 1'b1);
      end
      n_cmp++;
      if (cnt !== HOLD) begin
         n_err++; $display("FAIL runon_len got %0d exp %0d", cnt, HOLD);
      end
      n_cmp++;
      if ({estado, ventilador} !== 3'b000) begin
         n_err++; $display("FAIL runon_end got %b exp 000", {estado, ventilador});
      end
      for (int i = 0; i < 8; i++) step(2'b11, 1'b0, 1'b1);
      n = 0;
      while (estado != 2'b10 && n < 20) begin step(2'b00, 1'b0, 1'b1); n++; end
      for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b1);
      saw_reposo = 1'b0;
      n = 0;
      while (estado != 2'b11 && n < 20) begin
         step(2'b11, 1'b0, 1'b1);
         if (estado == 2'b00) saw_reposo = 1'b1;
         n++;
      end
      n_cmp++;
      if (estado !== 2'b11 || saw_reposo) begin
         n_err++; $display("FAIL runon_realert got est=%b reposo_seen=%0d exp est=11 reposo_seen=0", estado, saw_reposo);
      end
   endtask

   task automatic test_silence();
      int n;
      step(2'b00, 1'b0, 1'b0);
      n = 0;
      while (estado != 2'b01 && n < 20) begin step(2'b01, 1'b0, 1'b1); n++; end
      n_cmp++;
      if ({estado, buzzer} !== 3'b011) begin
         n_err++; $display("FAIL sil_pre_entry got %b exp 011", {estado, buzzer});
      end
      step(2'b01, 1'b1, 1'b1);
      n_cmp++;
      if ({estado, buzzer} !== 3'b010) begin
         n_err++; $display("FAIL sil_pre_ack got %b exp 010", {estado, buzzer});
      end
      n = 0;
      while (estado != 2'b11 && n < 20) begin
         step(2'b11, 1'b0, 1'b1);
         n_cmp++;
         if ({estado, ventilador, buzzer} !== exp_out()) begin
            n_err++; $display("FAIL sil_escalate got %b exp %b", {estado, ventilador, buzzer}, exp_out());
         end
         n++;
      end
      n_cmp++;
      if ({estado, ventilador, buzzer} !== 4'b1111) begin
         n_err++; $display("FAIL sil_alerta_resound got %b exp 1111", {estado, ventilador, buzzer});
      end
      step(2'b11, 1'b1, 1'b1);
      n_cmp++;
      if ({estado, ventilador, buzzer} !== 4'b1110) begin
         n_err++; $display("FAIL sil_alerta_ack got %b exp 1110", {estado, ventilador, buzzer});
      end
   endtask

   task automatic test_illegal();
      step(2'b00, 1'b0, 1'b0);
      for (int e = 1; e <= 10; e++) begin
         step(2'b10, 1'b0, 1'b1);
         n_cmp++;
         if ({estado, ventilador, buzzer} !== exp_out()) begin
            n_err++; $display("FAIL illegal_model edge %0d got %b exp %b", e, {estado, ventilador, buzzer}, exp_out());
         end
      end
      n_cmp++;
      if ({estado, ventilador} !== 3'b111) begin
         n_err++; $display("FAIL illegal_final got %b exp 111", {estado, ventilador});
      end
   endtask

   task automatic test_random();
      logic [1:0] s;
      int hold;
      logic a, r;
      step(2'b00, 1'b0, 1'b0);
      s = 2'b00; hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            s = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 25);
         end
         hold--;
         a = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 299) != 0);
         step(s, a, r);
         n_cmp++;
         if ({estado, ventilador, buzzer} !== exp_out()) begin
            n_err++; $display("FAIL random cyc %0d in=%b ack=%b got %b exp %b", c, s, a, {estado, ventilador, buzzer}, exp_out());
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_blink();
      test_runon();
      test_silence();
      test_illegal();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/control_actuadores.md
Name: control_actuadores

Overview:
- Consumer end of the 2-bit alert code produced by the alert/prevention logic (00 off, 01 intermediate temperature, 11 dangerous temperature).
- Filters the code, runs an alarm state machine and drives the physical actuators: buzzer and ventilation fan.
- Provides a user silence (acknowledge) input and reports its state for the display.

Parameters:
- DEB_CYC, 4: consecutive identical samples required before a new code is accepted (≥1).
- BLINK_CYC, 8: buzzer half-period in PRE state, in clock cycles (≥1).
- HOLD_CYC, 16: fan run-on time after the alert clears, in clock cycles (≥1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- Salida  in  2  alert code from the logic block; may glitch.
- ack  in  1  user silence button, already a single-cycle pulse.
- buzzer  out  1  audible alarm drive.
- ventilador  out  1  fan drive.
- estado  out  2  00 REPOSO, 01 PRE, 10 ENFRIA, 11 ALERTA.

Behaviour:
- Reset: rst_n=0 sampled at an edge forces state REPOSO, all counters 0, candidate=00, validated code=00, silencio=0, blink phase=0.
  - Outputs buzzer=0, ventilador=0, estado=00 from the following cycle.
  - Reset mid-alarm aborts immediately; no fan run-on.
- Code mapping: Salida=10 is illegal and is treated as 11 (fail-safe), in both the filter and the FSM.
- Filter:
  - Each edge, if mapped Salida ≠ candidate: candidate←Salida and deb_cnt←0.
  - Otherwise, if deb_cnt = DEB_CYC−1: validated←candidate.
  - Otherwise deb_cnt++ (saturating).
  - A change held stable is validated DEB_CYC+1 edges after first appearing. Shorter pulses are ignored.
- FSM (Moore): evaluates the validated code each edge; the new state is visible the cycle after validation. Outputs decode combinationally from registered state, silencio and blink phase.
  - REPOSO: buzzer=0, ventilador=0.
    - validated 01 → PRE.
    - validated 11 → ALERTA.
  - PRE: ventilador=0; buzzer = blink phase AND NOT silencio.
    - Blink phase starts at 1 on entry and toggles every BLINK_CYC cycles.
    - 00 → REPOSO; 11 → ALERTA.
  - ALERTA: ventilador=1; buzzer = NOT silencio.
    - 01 → PRE (fan stops immediately).
    - 00 → ENFRIA.
  - ENFRIA: ventilador=1, buzzer=0.
    - hold_cnt counts from 0 on entry; at HOLD_CYC−1 → REPOSO, so the fan runs exactly HOLD_CYC cycles.
    - 11 → ALERTA and 01 → PRE take priority over timeout.
- Silence:
  - ack=1 in PRE or ALERTA sets silencio next edge; the buzzer is forced 0 and the fan is unaffected.
  - ack is ignored in REPOSO and ENFRIA.
  - silencio clears on every state transition, so escalation PRE→ALERTA re-sounds the buzzer.
  - ack coinciding with a transition edge: the transition wins and silencio=0.
- Counters: widths are ceil(log2(param))+1. The blink and hold counters reset to 0 on every state entry. No wrap-around beyond terminal count.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with Salida=11 → buzzer=0, ventilador=0, estado=00. Release with Salida held 11 → estado=11 on the 6th edge after release, then buzzer=1, ventilador=1.
- Glitch filter: 3-cycle pulse Salida=01 from REPOSO → estado stays 00. A 5-cycle hold → estado=01.
- Blink: hold Salida=01 for 40 cycles → buzzer toggles every 8 cycles starting 1; ventilador=0 throughout.
- Run-on: ALERTA then Salida=00 → estado=10, ventilador=1 for exactly 16 cycles, then estado=00, ventilador=0. Salida=11 during ENFRIA → back to 11 with no REPOSO visit.
- Silence/escalation: PRE with ack pulse → buzzer=0 next cycle. Then Salida=11 → ALERTA with buzzer=1 again. A second ack → buzzer=0 while ventilador stays 1.
- Illegal code: Salida=10 held → behaves identically to 11 (estado=11, ventilador=1).
